// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bundle: imem request/response, decode handoff and redirect.
// master = fetch unit, slave = memory/decode/redirect side.
interface mips_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: credit-limited imem requests + FIFO.
// FETCH_PERF_CNT_EN adds perf_fetched/perf_squashed counters.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  mips_fetch_unit_if.master f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 2;
  localparam logic [UW-1:0] DEPTH_U = UW'(BUF_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;

  logic [31:0] buf_instr [BUF_DEPTH];
  logic [31:0] buf_pc    [BUF_DEPTH];

  logic [UW-1:0] used;
  logic          has_pend;
  logic          rsp_ok;
  logic          push;
  logic          squash;
  logic          pop;
  logic          acc;
  logic          redir;

  assign redir    = f.redirect_valid;
  assign used     = UW'(occ) + UW'(outst) + UW'(drop);
  assign has_pend = (outst != '0) || (drop != '0);
  assign rsp_ok   = f.imem_rsp_valid && has_pend;
  // A response is only kept when nothing stale is ahead of it.
  assign push     = rsp_ok && !redir && (drop == '0);
  assign squash   = rsp_ok && (redir || (drop != '0));

  assign f.imem_req_valid = !reset && !redir && (used < DEPTH_U);
  assign f.imem_req_addr  = fetch_pc;
  assign acc = f.imem_req_valid && f.imem_req_ready;

  assign f.if_valid = (occ != '0);
  assign f.if_instr = f.if_valid ? buf_instr[rd_ptr] : 32'h0;
  assign f.if_pc    = f.if_valid ? buf_pc[rd_ptr] : 32'h0;
  assign pop = f.if_valid && f.if_ready && !redir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
    end else if (redir) begin
      fetch_pc <= f.redirect_pc & 32'hFFFF_FFFC;
      rsp_pc   <= f.redirect_pc & 32'hFFFF_FFFC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      // In-flight requests become stale; one arriving now is already gone.
      drop     <= drop + outst - CW'(rsp_ok);
    end else begin
      if (acc)
        fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      occ   <= occ + CW'(push) - CW'(pop);
      outst <= outst + CW'(acc) - CW'(push);
      if (squash)
        drop <= drop - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= f.imem_rsp_data;
      buf_pc[wr_ptr]    <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      if (squash)
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && f.imem_rsp_valid && !has_pend)
      $error("mips_fetch_unit: response with nothing outstanding");
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: queue-level model, memory model, directed tests.
// Build with FETCH_PERF_CNT_EN to also check the perf counters.
module tb_mips_fetch_unit;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  mips_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .f    (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fetch, m_rsp, m_fetched, m_squashed;
  int          m_out, m_drop;
  int          lat = 1;
  int          cyc = 0;
  int          ncyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          first_acc = -1;
  int          first_v = -1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic exp_req();
    return !reset && !bus.redirect_valid &&
           (mq.size() + m_out + m_drop < D);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(string name, logic [31:0] q[$], int idx,
                       logic [31:0] exp);
    if (q.size() <= idx) begin
      checks++;
      errors++;
      $display("FAIL %s act=<none> exp=%h", name, exp);
    end else begin
      chk(name, q[idx], exp);
    end
  endtask

  task automatic model_init();
    mq.delete();
    memq.delete();
    m_fetch = 32'h0;
    m_rsp = 32'h0;
    m_out = 0;
    m_drop = 0;
    m_fetched = 0;
    m_squashed = 0;
  endtask

  // Spec-level model: advance once per rising edge from the stable inputs.
  task automatic model_update();
    logic acc, rsp, pop;
    logic [31:0] a;
    acc = exp_req() && bus.imem_req_ready;
    rsp = bus.imem_rsp_valid && (m_out + m_drop != 0);
    a = m_fetch;
    if (bus.imem_rsp_valid && memq.size() > 0)
      void'(memq.pop_front());
    if (reset) begin
      model_init();
    end else if (bus.redirect_valid) begin
      mq.delete();
      m_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
      m_rsp = m_fetch;
      m_drop = m_drop + m_out - (rsp ? 1 : 0);
      m_out = 0;
      if (rsp) m_squashed++;
    end else begin
      pop = (mq.size() > 0) && bus.if_ready;
      if (pop) void'(mq.pop_front());
      if (rsp) begin
        if (m_drop > 0) begin
          m_drop--;
          m_squashed++;
        end else begin
          mq.push_back('{bus.imem_rsp_data, m_rsp});
          m_rsp += 32'd4;
          m_out--;
          m_fetched++;
        end
      end
      if (acc) begin
        m_out++;
        m_fetch += 32'd4;
        memq.push_back('{a, cyc + lat});
      end
    end
    cyc++;
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk);
      model_update();
    end
  end

  // Compare process: every falling edge against the model.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'h0);
        chk("rst_perf_squashed", perf_squashed, 32'h0);
`endif
      end else begin
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req()));
        if (exp_req())
          chk("req_addr", bus.imem_req_addr, m_fetch);
        chk("if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("if_instr", bus.if_instr, mq[0].instr);
          chk("if_pc", bus.if_pc, mq[0].pc);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_squashed", perf_squashed, m_squashed);
`endif
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          acc_log.push_back(bus.imem_req_addr);
          if (first_acc < 0) first_acc = ncyc;
        end
        if (bus.if_valid && first_v < 0) first_v = ncyc;
        if (bus.if_valid && bus.if_ready && !bus.redirect_valid)
          pop_log.push_back(bus.if_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    first_acc = -1;
    first_v = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    steps(2);
    clear_logs();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #2;
    chk("init_if_valid", 32'(bus.if_valid), 32'h0);
    chk("init_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("init_if_pc", bus.if_pc, 32'h0);

    // 1: streaming, latency 1
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    do_reset();
    steps(10);
    chk_q("t1_acc0", acc_log, 0, 32'h0);
    chk_q("t1_acc1", acc_log, 1, 32'h4);
    chk_q("t1_acc2", acc_log, 2, 32'h8);
    chk_q("t1_acc3", acc_log, 3, 32'hC);
    chk_q("t1_pop0", pop_log, 0, 32'h0);
    chk_q("t1_pop1", pop_log, 1, 32'h4);
    chk_q("t1_pop2", pop_log, 2, 32'h8);
    chk("t1_latency", 32'(first_v - first_acc), 32'd2);

    // 2: decode stalled
    bus.if_ready = 1'b0;
    do_reset();
    steps(8);
    chk("t2_nreq", 32'(acc_log.size()), 32'(D));
    chk("t2_if_valid", 32'(bus.if_valid), 32'h1);
    chk("t2_if_pc", bus.if_pc, 32'h0);
    chk("t2_req_valid", 32'(bus.imem_req_valid), 32'h0);

    // 3: redirect with two requests in flight
    lat = 5;
    bus.if_ready = 1'b1;
    do_reset();
    steps(2);
    clear_logs();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    steps(15);
    chk_q("t3_acc0", acc_log, 0, 32'h100);
    chk_q("t3_pop0", pop_log, 0, 32'h100);
    chk_q("t3_pop1", pop_log, 1, 32'h104);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_squashed", perf_squashed, 32'd2);
`endif

    // 4: PC wrap at the top of the address space
    lat = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    clear_logs();
    step();
    bus.redirect_valid = 1'b0;
    steps(12);
    chk_q("t4_acc0", acc_log, 0, 32'hFFFF_FFFC);
    chk_q("t4_acc1", acc_log, 1, 32'h0);
    chk_q("t4_pop0", pop_log, 0, 32'hFFFF_FFFC);
    chk_q("t4_pop1", pop_log, 1, 32'h0);

    // 5: reset with buffered data and a request outstanding
    lat = 3;
    bus.if_ready = 1'b0;
    do_reset();
    steps(4);
    chk("t5_pre_if_valid", 32'(bus.if_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_if_valid", 32'(bus.if_valid), 32'h0);
    chk("t5_req_valid", 32'(bus.imem_req_valid), 32'h0);
    lat = 1;
    bus.if_ready = 1'b1;
    do_reset();
    steps(6);
    chk_q("t5_acc0", acc_log, 0, 32'h0);
    chk_q("t5_pop0", pop_log, 0, 32'h0);

    // Mixed handshakes and occasional redirects, model-checked
    lat = 2;
    for (int i = 0; i < 80; i++) begin
      bus.if_ready = 1'($urandom_range(0, 1));
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = (i % 13 == 7);
      bus.redirect_pc = $urandom;
      step();
    end
    bus.redirect_valid = 1'b0;
    steps(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
